// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: datapath width, instruction size and the
// fetch sequencer state encoding.
package cpu_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef logic [1:0] fstate_t;

    localparam fstate_t FS_IDLE = 2'd0;
    localparam fstate_t FS_REQ  = 2'd1;
    localparam fstate_t FS_WAIT = 2'd2;
    localparam fstate_t FS_HOLD = 2'd3;

    // Fetch addresses are always word aligned; the low bits of a target are ignored.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response channel plus the fetch-to-decode handoff.
interface fetch_ctrl_if;
    import cpu_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_instr;
    logic            if_ready;

    // master = fetch sequencer; slave = memory + decode environment
    modport master (
        output imem_req, imem_addr, if_valid, if_pc, if_instr,
        input  imem_ready, imem_rvalid, imem_rdata, if_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_pc, if_instr,
        output imem_ready, imem_rvalid, imem_rdata, if_ready
    );

endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, keeps one memory request in flight,
// discards responses made stale by a redirect and holds each word for decode.
module fetch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_addr,
    input  logic             stall,
    fetch_ctrl_if.master     bus,
    output logic [XLEN-1:0]  pc_q,
    output logic [CNT_W-1:0] drop_cnt
);

    fstate_t         state, state_nxt;
    logic            stale;
    logic            req_hold;
    logic            if_valid_q;
    logic [XLEN-1:0] if_pc_q;
    logic [XLEN-1:0] if_instr_q;

    logic            redir;
    logic            issue;
    logic            consume;
    logic            req_c;

    // Redirects arriving before the first request are not architecturally visible.
    assign redir   = redirect_valid && (state != FS_IDLE);
    assign issue   = req_c && bus.imem_ready;
    assign consume = if_valid_q && bus.if_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FS_IDLE;
            pc_q       <= RESET_PC;
            stale      <= 1'b0;
            req_hold   <= 1'b0;
            drop_cnt   <= '0;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_instr_q <= '0;
        end else begin
            state    <= state_nxt;
            req_hold <= req_c && !bus.imem_ready && !redir;

            if (redir)
                pc_q <= align_pc(redirect_addr);
            else if (issue)
                pc_q <= pc_q + XLEN'(INSTR_BYTES);

            case (state)
                FS_REQ: begin
                    // A request issued alongside a redirect fetches the wrong path.
                    if (issue)
                        stale <= redir;
                end
                FS_WAIT: begin
                    if (bus.imem_rvalid) begin
                        stale <= 1'b0;
                        if (stale || redir) begin
                            if (drop_cnt != {CNT_W{1'b1}})
                                drop_cnt <= drop_cnt + CNT_W'(1);
                        end else begin
                            if_valid_q <= 1'b1;
                            if_pc_q    <= pc_q - XLEN'(INSTR_BYTES);
                            if_instr_q <= bus.imem_rdata;
                        end
                    end else if (redir) begin
                        stale <= 1'b1;
                    end
                end
                FS_HOLD: begin
                    if (consume || redir)
                        if_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FS_IDLE: if (!stall) state_nxt = FS_REQ;
            FS_REQ:  if (issue) state_nxt = FS_WAIT;
            FS_WAIT: if (bus.imem_rvalid) state_nxt = (stale || redir) ? FS_REQ : FS_HOLD;
            FS_HOLD: if (consume || redir) state_nxt = FS_REQ;
            default: state_nxt = FS_IDLE;
        endcase
    end

    // Once presented, a request stays up through a late stall until accepted.
    always_comb begin
        req_c = 1'b0;
        if (state == FS_REQ)
            req_c = !stall || req_hold;
    end

    assign bus.imem_req  = req_c;
    assign bus.imem_addr = pc_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_pc     = if_pc_q;
    assign bus.if_instr  = if_instr_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized scoreboard bench for fetch_ctrl with a transaction-level fetch model.
module tb_fetch_ctrl;
    import cpu_pkg::*;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic        stall = 1'b0;
    logic [31:0] pc_q;
    logic [15:0] drop_cnt;

    fetch_ctrl_if bus();

    fetch_ctrl #(.RESET_PC(RPC), .CNT_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .stall          (stall),
        .bus            (bus),
        .pc_q           (pc_q),
        .drop_cnt       (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

    int          errors = 0;
    int          checks = 0;
    ent_t        exp_q[$];
    logic [31:0] exp_pc = RPC;
    logic [31:0] out_addr = '0;
    logic [31:0] prev_addr = '0;
    logic [31:0] mem_addr = '0;
    bit          outst = 0, out_stale = 0, prev_hold = 0, armed = 0, mem_busy = 0;
    bit          redir = 0, done = 0, final_done = 0;
    int          mem_lat = 0, exp_drops = 0, n_cons = 0;
    ent_t        e;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor + reference model: sampled on the falling edge, describes the coming rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_pc_q", pc_q, RPC);
            chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
            chk("rst_imem_addr", bus.imem_addr, RPC);
            chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
            chk("rst_if_pc", bus.if_pc, 32'd0);
            chk("rst_if_instr", bus.if_instr, 32'd0);
            chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
            exp_pc = RPC; outst = 0; out_stale = 0; exp_drops = 0; exp_q.delete();
            armed = 0; mem_busy = 0; prev_hold = 0;
        end else begin
            redir = redirect_valid;
            chk("pc_q", pc_q, exp_pc);
            chk("drop_cnt", 32'(drop_cnt), 32'(exp_drops));
            chk("if_valid", 32'(bus.if_valid), 32'(exp_q.size() != 0));
            if (prev_hold) begin
                chk("req_held", 32'(bus.imem_req), 32'd1);
                chk("addr_held", bus.imem_addr, prev_addr);
            end
            if (bus.if_valid && exp_q.size() != 0) begin
                chk("if_pc", bus.if_pc, exp_q[0].pc);
                chk("if_instr", bus.if_instr, exp_q[0].instr);
                if (bus.if_ready) begin
                    void'(exp_q.pop_front());
                    n_cons++;
                end else if (redir) begin
                    void'(exp_q.pop_front());
                end
            end
            if (bus.imem_rvalid) begin
                if (out_stale || redir) begin
                    if (exp_drops < 16'hFFFF) exp_drops++;
                end else begin
                    e.pc = out_addr; e.instr = mem_word(out_addr);
                    exp_q.push_back(e);
                end
                outst = 0; mem_busy = 0;
            end else begin
                if (redir && outst) out_stale = 1;
                if (mem_busy && mem_lat > 0) mem_lat--;
            end
            if (bus.imem_req && bus.imem_ready) begin
                chk("issue_addr", bus.imem_addr, exp_pc);
                chk("one_outstanding", 32'(outst), 32'd0);
                outst = 1; out_addr = bus.imem_addr; out_stale = redir;
                exp_pc = bus.imem_addr + 32'd4;
                mem_busy = 1; mem_addr = bus.imem_addr; mem_lat = int'($urandom_range(0, 2));
                armed = 1;
            end
            if (redir) exp_pc = redirect_addr & 32'hFFFF_FFFC;
            prev_hold = bus.imem_req && !bus.imem_ready && !redir;
            prev_addr = bus.imem_addr;
            if (done && !final_done) begin
                chk("progress", 32'(n_cons > 50), 32'd1);
                final_done = 1;
            end
        end
    end

    task automatic cyc(input int p_rdy, input int p_ifr, input int p_st, input int p_rd);
        @(posedge clk); #1;
        bus.imem_ready = ($urandom_range(0, 99) < p_rdy);
        bus.if_ready   = ($urandom_range(0, 99) < p_ifr);
        stall          = ($urandom_range(0, 99) < p_st);
        redirect_valid = armed && ($urandom_range(0, 99) < p_rd);
        case ($urandom_range(0, 3))
            0:       redirect_addr = 32'hFFFF_FFFC;
            1:       redirect_addr = 32'h0000_3003;
            2:       redirect_addr = 32'h0000_2000;
            default: redirect_addr = $urandom;
        endcase
        bus.imem_rvalid = mem_busy && (mem_lat == 0);
        bus.imem_rdata  = bus.imem_rvalid ? mem_word(mem_addr) : $urandom;
    endtask

    initial begin
        bus.imem_ready = 0; bus.imem_rvalid = 0; bus.imem_rdata = '0; bus.if_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20)  cyc(100, 100, 0, 0);   // straight-line fetch from RESET_PC
        repeat (400) cyc(70, 60, 15, 8);
        repeat (150) cyc(50, 15, 10, 4);    // decode back-pressure, long holds
        repeat (150) cyc(25, 90, 0, 6);     // slow memory accept
        for (int i = 0; i < 60; i++) begin
            cyc(70, 60, 0, 0);
            if (mem_busy) break;
        end
        #1 rst_n = 1'b0;                    // reset while a request is outstanding
        repeat (3) cyc(70, 60, 0, 0);
        rst_n = 1'b1;
        repeat (400) cyc(70, 60, 15, 8);
        done = 1;
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
